// File: rtl/lead_count_unit_pkg.sv
// =============================================================================
// lead_count_unit_pkg : shared ALU types for the leading-bit search unit
// Rev 1.0
// =============================================================================
`default_nettype none

package lead_count_unit_pkg;

   typedef enum logic [1:0] {
      LC_MSB = 2'b00,
      LC_CLZ = 2'b01,
      LC_CLO = 2'b10
   } lc_mode_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      SCAN = 2'b01,
      DONE = 2'b10
   } lc_state_t;

   // The reserved encoding 2'b11 behaves as an MSB-index request.
   function automatic lc_mode_t decode_mode(input logic [1:0] m);
      case (m)
         2'b01:   return LC_CLZ;
         2'b10:   return LC_CLO;
         default: return LC_MSB;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/lead_count_unit_msb_chunk.sv
// =============================================================================
// msb_chunk : combinational priority encoder, highest set bit of one chunk
// Rev 1.0
// =============================================================================
`default_nettype none

module msb_chunk #(
   parameter  int CHUNK = 8,
   localparam int IW    = $clog2(CHUNK)
) (
   input  logic [CHUNK-1:0] chunk,
   output logic             hit,
   output logic [IW-1:0]    idx
);

   always_comb begin
      hit = |chunk;
      idx = '0;
      for (int i = 0; i < CHUNK; i++) begin
         if (chunk[i]) idx = IW'(i);
      end
   end

endmodule

`default_nettype wire

// File: rtl/lead_count_unit.sv
// =============================================================================
// lead_count_unit : multi-cycle MSB-index / CLZ / CLO search, CHUNK bits/cycle.
// Option macro LEAD_COUNT_EARLY_EXIT_EN: leave SCAN on the first hit.  Rev 1.0
// =============================================================================
`default_nettype none

module lead_count_unit
   import lead_count_unit_pkg::*;
#(
   parameter  int WIDTH = 32,
   parameter  int CHUNK = 8,
   localparam int CW    = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CW-1:0]    out_count,
   output logic             out_zero
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IW     = $clog2(CHUNK);
   localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   generate
      if ((CHUNK < 2) || ((CHUNK & (CHUNK - 1)) != 0) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
         $error("lead_count_unit: WIDTH must be a multiple of CHUNK, CHUNK a power of two >= 2");
      end
   endgenerate

   lc_state_t        state, next_state;
   lc_mode_t         mode, in_mode_dec;
   logic [WIDTH-1:0] opnd;
   logic [KW-1:0]    k;
   logic [CW-1:0]    count_q;
   logic             zero_q;

   logic             accept, last_chunk, scan_end;
   logic             chunk_hit;
   logic [IW-1:0]    chunk_idx;
   logic [CW-1:0]    pos, hit_count, miss_count, final_count;
   logic             final_zero;

   assign in_mode_dec = decode_mode(in_mode);
   assign accept      = in_valid && in_ready;
   assign last_chunk  = (k == '0);

   // The operand shifts left each miss, so the chunk under test is always the top one.
   msb_chunk #(.CHUNK(CHUNK)) u_msb_chunk (
      .chunk (opnd[WIDTH-1 -: CHUNK]),
      .hit   (chunk_hit),
      .idx   (chunk_idx)
   );

   assign pos        = CW'(k) * CW'(CHUNK) + CW'(chunk_idx);
   assign hit_count  = (mode == LC_MSB) ? pos : (CW'(WIDTH - 1) - pos);
   assign miss_count = (mode == LC_MSB) ? '0  : CW'(WIDTH);

`ifdef LEAD_COUNT_EARLY_EXIT_EN
   assign scan_end    = chunk_hit || last_chunk;
   assign final_count = chunk_hit ? hit_count : miss_count;
   assign final_zero  = !chunk_hit;
`else
   logic          found;
   logic [CW-1:0] saved_count;

   // Scanning always runs to chunk 0; only the first (highest) hit is kept.
   assign scan_end    = last_chunk;
   assign final_count = found ? saved_count : (chunk_hit ? hit_count : miss_count);
   assign final_zero  = !found && !chunk_hit;

   always_ff @(posedge clk) begin
      if (reset) begin
         found       <= 1'b0;
         saved_count <= '0;
      end else if (state == IDLE) begin
         found       <= 1'b0;
      end else if ((state == SCAN) && chunk_hit && !found) begin
         found       <= 1'b1;
         saved_count <= hit_count;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept)    next_state = SCAN;
         SCAN:    if (scan_end)  next_state = DONE;
         DONE:    if (out_ready) next_state = IDLE;
         default:                next_state = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE) && !reset;
      out_valid = (state == DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         opnd    <= '0;
         mode    <= LC_MSB;
         k       <= KW'(NCHUNK - 1);
         count_q <= '0;
         zero_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  // CLO searches for the first 0, i.e. the first 1 of the inverse.
                  opnd <= (in_mode_dec == LC_CLO) ? ~in_data : in_data;
                  mode <= in_mode_dec;
                  k    <= KW'(NCHUNK - 1);
               end
            end
            SCAN: begin
               if (scan_end) begin
                  count_q <= final_count;
                  zero_q  <= final_zero;
               end else begin
                  k    <= k - KW'(1);
                  opnd <= opnd << CHUNK;
               end
            end
            default: ;
         endcase
      end
   end

   assign out_count = count_q;
   assign out_zero  = zero_q;

endmodule

`default_nettype wire
